// File: rtl/msk_pkg.sv
// msk_pkg: shared defaults, FSM states and the elaboration-time cos/sin generator for msk_mod.
package msk_pkg;
    localparam int OSF_DEF = 20;

    typedef enum logic {IDLE, RUN} state_e;

    // round(amp*cos(2*pi*k/n)); sine is obtained by calling with k - n/4
    function automatic int cos_q(input int k, input int n, input int amp);
        real a, t, s;
        int m;
        m = ((k % n) + n) % n;
        if (2 * m > n) m = n - m;
        a = 6.283185307179586 * m / n;
        t = 1.0;
        s = 1.0;
        for (int j = 1; j < 30; j++) begin
            t = -t * a * a / ((2 * j - 1) * (2 * j));
            s = s + t;
        end
        s = s * amp;
        return $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
    endfunction
endpackage

// File: rtl/msk_mod_if.sv
// msk_mod_if: bit-input handshake and I/Q sample output bundle for msk_mod.
interface msk_mod_if #(parameter int WO = 16);
    logic                 ce_i, data_i, data_val_i, data_rdy_o;
    logic signed [WO-1:0] i_o, q_o;
    logic                 iq_val_o, sym_start_o, underrun_o;
    modport master (output ce_i, data_i, data_val_i,
                    input  data_rdy_o, i_o, q_o, iq_val_o, sym_start_o, underrun_o);
    modport slave  (input  ce_i, data_i, data_val_i,
                    output data_rdy_o, i_o, q_o, iq_val_o, sym_start_o, underrun_o);
endinterface

// File: rtl/msk_sincos_lut.sv
// msk_sincos_lut: registered phase -> I/Q lookup; output is forced to 0 when no sample is valid.
module msk_sincos_lut import msk_pkg::*; #(
    parameter  int OSF = OSF_DEF,
    parameter  int WO  = 16,
    parameter  int AMP = 2**(WO-1)-1,
    localparam int N   = 4*OSF,
    localparam int PW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PW-1:0]        ph_i,
    input  logic                 val_i,
    output logic signed [WO-1:0] i_o,
    output logic signed [WO-1:0] q_o
);
    logic signed [WO-1:0] cos_t [N];
    logic signed [WO-1:0] sin_t [N];

    for (genvar k = 0; k < N; k++) begin : g_tbl
        localparam logic signed [WO-1:0] C = WO'(cos_q(k, N, AMP));
        localparam logic signed [WO-1:0] S = WO'(cos_q(k - OSF, N, AMP));
        assign cos_t[k] = C;
        assign sin_t[k] = S;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            i_o <= '0;
            q_o <= '0;
        end else begin
            i_o <= val_i ? cos_t[ph_i] : '0;
            q_o <= val_i ? sin_t[ph_i] : '0;
        end
endmodule

// File: rtl/msk_mod.sv
// msk_mod: MSK modulator; one held input bit steers the phase index +/-1 per ce_i, I/Q 2 cycles later.
// Define MSK_MOD_PRECODE_EN to differentially precode the bits (d_k = b_k ^ d_k-1) before steering.
module msk_mod import msk_pkg::*; #(
    parameter int OSF = OSF_DEF,
    parameter int WO  = 16,
    parameter int AMP = 2**(WO-1)-1
) (
    input logic      clk,
    input logic      rst,
    msk_mod_if.slave bus
);
    localparam int N  = 4*OSF;
    localparam int PW = $clog2(N);
    localparam int SW = $clog2(OSF);

    state_e        st_q, st_d;
    logic [PW-1:0] ph_q, ph_d, s1_ph_q;
    logic [SW-1:0] sc_q, sc_d;
    logic          hold_q, hold_d, hbit_q, hbit_d, dir_q, dir_d;
    logic          s1_val_q, s1_sym_q, s1_und_q, s2_val_q, s2_sym_q, s2_und_q;
    logic          load, und, emit, sym_bit, dir;

`ifdef MSK_MOD_PRECODE_EN
    logic pre_q;
    assign sym_bit = hbit_q ^ pre_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) pre_q <= 1'b0;
        else if (und) pre_q <= 1'b0;
        else if (load) pre_q <= sym_bit;
`else
    assign sym_bit = hbit_q;
`endif

    // sc stays 0 in IDLE, so a ce_i there is treated as a symbol boundary
    always_comb begin
        load   = bus.ce_i && sc_q == '0 && hold_q;
        und    = bus.ce_i && sc_q == '0 && !hold_q && st_q == RUN;
        emit   = load || (bus.ce_i && st_q == RUN && sc_q != '0);
        dir    = load ? sym_bit : dir_q;
        st_d   = und ? IDLE : load ? RUN : st_q;
        hold_d = load ? 1'b0 : hold_q || bus.data_val_i;
        hbit_d = (bus.data_val_i && !hold_q) ? bus.data_i : hbit_q;
        dir_d  = dir;
        sc_d   = und ? '0 : !emit ? sc_q : sc_q == SW'(OSF-1) ? '0 : sc_q + 1'b1;
        ph_d   = und ? '0 : !emit ? ph_q :
                 dir ? (ph_q == PW'(N-1) ? '0 : ph_q + 1'b1) :
                       (ph_q == '0 ? PW'(N-1) : ph_q - 1'b1);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st_q     <= IDLE;
            ph_q     <= '0;
            sc_q     <= '0;
            hold_q   <= 1'b0;
            hbit_q   <= 1'b0;
            dir_q    <= 1'b0;
            s1_ph_q  <= '0;
            s1_val_q <= 1'b0;
            s1_sym_q <= 1'b0;
            s1_und_q <= 1'b0;
            s2_val_q <= 1'b0;
            s2_sym_q <= 1'b0;
            s2_und_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            ph_q     <= ph_d;
            sc_q     <= sc_d;
            hold_q   <= hold_d;
            hbit_q   <= hbit_d;
            dir_q    <= dir_d;
            if (emit) s1_ph_q <= ph_q;
            s1_val_q <= emit;
            s1_sym_q <= load;
            s1_und_q <= und;
            s2_val_q <= s1_val_q;
            s2_sym_q <= s1_sym_q;
            s2_und_q <= s1_und_q;
        end

    msk_sincos_lut #(.OSF(OSF), .WO(WO), .AMP(AMP)) u_lut (
        .clk   (clk),
        .rst   (rst),
        .ph_i  (s1_ph_q),
        .val_i (s1_val_q),
        .i_o   (bus.i_o),
        .q_o   (bus.q_o)
    );

    assign bus.data_rdy_o  = !hold_q;
    assign bus.iq_val_o    = s2_val_q;
    assign bus.sym_start_o = s2_sym_q;
    assign bus.underrun_o  = s2_und_q;
endmodule

// File: tb/tb_msk_mod.sv
// tb_msk_mod: directed MSK vectors; expected samples queued up front, a monitor pops and compares each output.
module tb_msk_mod;
    import msk_pkg::*;

    typedef struct {
        logic               chk;
        logic               sym;
        logic signed [15:0] i;
        logic signed [15:0] q;
    } exp_t;

    logic clk, rst;
    int   checks, errors, nsamp, und_cnt, ce_mode;
    exp_t sb[$];

    msk_mod_if #(.WO(16)) bus ();

    msk_mod #(.OSF(20), .WO(16), .AMP(32767)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ce_i: 0 = off, 1 = every cycle, 2 = every third cycle
    initial begin
        int c;
        c = 0;
        bus.ce_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.ce_i = (ce_mode == 1) || (ce_mode == 2 && c == 0);
            c = (c == 2) ? 0 : c + 1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.underrun_o) und_cnt++;
            if (bus.iq_val_o) begin
                check("sample_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check($sformatf("sym_start[%0d]", nsamp), bus.sym_start_o, e.sym);
                    if (e.chk) begin
                        check($sformatf("i[%0d]", nsamp), bus.i_o, e.i);
                        check($sformatf("q[%0d]", nsamp), bus.q_o, e.q);
                    end
                end
                nsamp++;
            end
        end
    end

    task automatic plan(input int n);
        for (int k = 0; k < n; k++) sb.push_back('{1'b0, (k % 20) == 0, 16'sd0, 16'sd0});
    endtask

    task automatic want(input int k, input int i, input int q);
        sb[k].chk = 1'b1;
        sb[k].i   = 16'(i);
        sb[k].q   = 16'(q);
    endtask

    task automatic start_test();
        rst = 1'b1;
        ce_mode = 0;
        bus.data_val_i = 1'b0;
        bus.data_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        nsamp = 0;
        und_cnt = 0;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        for (int t = 0; t < 3000 && !bus.data_rdy_o; t++) @(negedge clk);
        check("send_ready", bus.data_rdy_o, 1);
        bus.data_i = b;
        bus.data_val_i = 1'b1;
        @(negedge clk);
        bus.data_val_i = 1'b0;
    endtask

    task automatic end_test(input int exp_und);
        for (int t = 0; t < 3000 && und_cnt < exp_und; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("underruns", und_cnt, exp_und);
        check("leftover_samples", sb.size(), 0);
        check("idle_val", bus.iq_val_o, 0);
        check("idle_i", bus.i_o, 0);
        check("idle_q", bus.q_o, 0);
        check("idle_rdy", bus.data_rdy_o, 1);
    endtask

    initial begin
        int  acc;
        logic prev;
        checks = 0; errors = 0; nsamp = 0; und_cnt = 0; ce_mode = 0;
        rst = 1'b1;
        bus.data_i = 1'b0;
        bus.data_val_i = 1'b0;
        @(negedge clk);
        check("rst_rdy", bus.data_rdy_o, 1);
        check("rst_i", bus.i_o, 0);
        check("rst_q", bus.q_o, 0);
        check("rst_val", bus.iq_val_o, 0);
        check("rst_sym", bus.sym_start_o, 0);
        check("rst_und", bus.underrun_o, 0);

        // bits 1,1,1 with continuous ce
        start_test();
        plan(60);
        want(0, 32767, 0);
        want(10, 23170, 23170);
        want(20, 0, 32767);
`ifdef MSK_MOD_PRECODE_EN
        want(40, 32767, 0);
`else
        want(40, -32767, 0);
`endif
        ce_mode = 1;
        send_bit(1); send_bit(1); send_bit(1);
        end_test(1);

        // bits 1,0,1: phase turns back
        start_test();
        plan(60);
        want(20, 0, 32767);
`ifdef MSK_MOD_PRECODE_EN
        want(40, -32767, 0);
`else
        want(40, 32767, 0);
`endif
        ce_mode = 1;
        send_bit(1); send_bit(0); send_bit(1);
        end_test(1);

        // bits 0 x5: downward wrap 0 -> 79 and back to 0 after 80 steps
        start_test();
        plan(100);
        want(0, 32767, 0);
        want(1, 32666, -2571);
        want(20, 0, -32767);
        want(40, -32767, 0);
        want(80, 32767, 0);
        ce_mode = 1;
        for (int b = 0; b < 5; b++) send_bit(0);
        end_test(1);

        // single bit, then underrun and silence
        start_test();
        plan(20);
        want(19, 2571, 32666);
        ce_mode = 1;
        send_bit(1);
        end_test(1);
        repeat (40) @(negedge clk);
        check("idle_after_underrun_val", bus.iq_val_o, 0);

        // ce every third cycle, data_val held high
        start_test();
        plan(60);
        want(20, 0, 32767);
        ce_mode = 2;
        bus.data_i = 1'b1;
        bus.data_val_i = 1'b1;
        acc = 0;
        prev = 1'b0;
        for (int t = 0; t < 3000 && acc < 3; t++) begin
            if (bus.data_rdy_o) begin
                acc++;
                check("rdy_single_cycle", prev, 0);
            end
            prev = bus.data_rdy_o;
            @(negedge clk);
        end
        bus.data_val_i = 1'b0;
        check("bits_accepted", acc, 3);
        end_test(1);

        // reset in the middle of a symbol
        start_test();
        plan(20);
        ce_mode = 1;
        send_bit(1);
        send_bit(0);
        for (int t = 0; t < 500 && nsamp < 7; t++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_i", bus.i_o, 0);
        check("midrst_q", bus.q_o, 0);
        check("midrst_val", bus.iq_val_o, 0);
        check("midrst_sym", bus.sym_start_o, 0);
        check("midrst_und", bus.underrun_o, 0);
        check("midrst_rdy", bus.data_rdy_o, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        end_test(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
